// File: rtl/button_conditioner_if.sv
// Button bundle between the raw push-button pins and the stopwatch control FSM.
interface button_conditioner_if #(
  parameter int unsigned N_BUTTONS = 4
);
  logic [N_BUTTONS-1:0] btn_raw;
  logic [N_BUTTONS-1:0] btn_level;
  logic [N_BUTTONS-1:0] btn_pulse;

  modport master (output btn_raw, input btn_level, input btn_pulse);
  modport slave  (input btn_raw, output btn_level, output btn_pulse);
endinterface

// File: rtl/button_conditioner.sv
// Stopwatch button front end: per channel a 2-flop synchronizer, a stable-time
// debounce counter, a registered debounced level and a one-cycle press pulse.
module button_conditioner #(
  parameter int unsigned N_BUTTONS       = 4,
  parameter int unsigned DEBOUNCE_CYCLES = 500_000
) (
  input  logic                clk,
  input  logic                n_rst,
  button_conditioner_if.slave btn_if
);
  localparam int unsigned      CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [N_BUTTONS-1:0] s1_q, s1_d;
  logic [N_BUTTONS-1:0] s2_q, s2_d;
  logic [N_BUTTONS-1:0] level_q, level_d;
  logic [N_BUTTONS-1:0] pulse_q, pulse_d;
  logic [CNT_W-1:0]     cnt_q [N_BUTTONS];
  logic [CNT_W-1:0]     cnt_d [N_BUTTONS];

  // Next state: synchronize, then flip the level after DEBOUNCE_CYCLES consecutive mismatches.
  always_comb begin
    s1_d    = btn_if.btn_raw;
    s2_d    = s1_q;
    level_d = level_q;
    pulse_d = '0;
    for (int unsigned i = 0; i < N_BUTTONS; i++) begin
      cnt_d[i] = '0;
      if (s2_q[i] != level_q[i]) begin
        if (cnt_q[i] == CNT_LAST) begin
          level_d[i] = s2_q[i];
          pulse_d[i] = s2_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + CNT_W'(1);
        end
      end
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      s1_q    <= '0;
      s2_q    <= '0;
      level_q <= '0;
      pulse_q <= '0;
      for (int unsigned i = 0; i < N_BUTTONS; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      s1_q    <= s1_d;
      s2_q    <= s2_d;
      level_q <= level_d;
      pulse_q <= pulse_d;
      for (int unsigned i = 0; i < N_BUTTONS; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  assign btn_if.btn_level = level_q;
  assign btn_if.btn_pulse = pulse_q;
endmodule

// File: tb/tb_button_conditioner.sv
// Bench for button_conditioner: directed scenarios plus random bouncing input,
// checked against a sliding-window model of the debounce rule.
`timescale 1ns/1ps
module tb_button_conditioner;
  localparam int unsigned N      = 4;
  localparam int unsigned D      = 4;
  localparam int unsigned D_LONG = 1000;

  logic clk = 1'b0;
  logic n_rst;
  always #5 clk = ~clk;

  button_conditioner_if #(.N_BUTTONS(N)) bus ();
  button_conditioner_if #(.N_BUTTONS(N)) bus_long ();

  button_conditioner #(.N_BUTTONS(N), .DEBOUNCE_CYCLES(D)) dut (
    .clk(clk), .n_rst(n_rst), .btn_if(bus)
  );
  button_conditioner #(.N_BUTTONS(N), .DEBOUNCE_CYCLES(D_LONG)) dut_long (
    .clk(clk), .n_rst(n_rst), .btn_if(bus_long)
  );

  int checks = 0;
  int errors = 0;

  // Model: the synchronized value seen after each edge is kept in a window of
  // the last D edges; a level flips when every entry in the window disagrees.
  logic [N-1:0] m_s1, m_s2, m_lvl, m_pul;
  logic [N-1:0] m_hist[$];

  task automatic model_reset_state();
    m_s1 = '0; m_s2 = '0; m_lvl = '0; m_pul = '0;
    m_hist = {};
    for (int j = 0; j < int'(D); j++) m_hist.push_back('0);
  endtask

  task automatic model_edge();
    bit flip;
    if (!n_rst) begin
      model_reset_state();
    end else begin
      m_pul = '0;
      for (int c = 0; c < int'(N); c++) begin
        flip = 1'b1;
        foreach (m_hist[j]) if (m_hist[j][c] == m_lvl[c]) flip = 1'b0;
        if (flip) begin
          m_lvl[c] = ~m_lvl[c];
          m_pul[c] = m_lvl[c];
        end
      end
      m_s2 = m_s1;
      m_s1 = bus.btn_raw;
      m_hist.push_back(m_s2);
      void'(m_hist.pop_front());
    end
  endtask

  // One clock: model follows the edge, outputs are then sampled 1ns later.
  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic test_reset();
    logic [N-1:0] exp_lvl, exp_pul;
    n_rst = 1'b0;
    bus.btn_raw = '1;
    bus_long.btn_raw = '0;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (bus.btn_level !== '0 || bus.btn_pulse !== '0) begin
        errors++;
        $display("FAIL reset_hold edge %0d: level=%b pulse=%b, required 0000/0000", i, bus.btn_level, bus.btn_pulse);
      end
    end
    n_rst = 1'b1;
    for (int j = 0; j <= 6; j++) begin
      step();
      exp_lvl = (j >= 5) ? {N{1'b1}} : {N{1'b0}};
      exp_pul = (j == 5) ? {N{1'b1}} : {N{1'b0}};
      checks++;
      if (bus.btn_level !== exp_lvl || bus.btn_pulse !== exp_pul ||
          bus.btn_level !== m_lvl || bus.btn_pulse !== m_pul) begin
        errors++;
        $display("FAIL reset_release k+%0d: level=%b pulse=%b, required %b/%b", j, bus.btn_level, bus.btn_pulse, exp_lvl, exp_pul);
      end
    end
  endtask

  task automatic test_clean_press();
    int pulses = 0, first_pulse = -1, first_lvl = -1;
    bit stray = 1'b0;
    bus.btn_raw = '0;
    repeat (12) step();
    checks++;
    if (bus.btn_level !== '0) begin
      errors++;
      $display("FAIL press_settle: level=%b, required 0000", bus.btn_level);
    end
    bus.btn_raw = 4'b0001;
    for (int j = 0; j < 20; j++) begin
      step();
      checks++;
      if (bus.btn_level !== m_lvl || bus.btn_pulse !== m_pul) begin
        errors++;
        $display("FAIL press_model k+%0d: level=%b pulse=%b, required %b/%b", j, bus.btn_level, bus.btn_pulse, m_lvl, m_pul);
      end
      if (bus.btn_pulse[0] === 1'b1) begin pulses++; first_pulse = j; end
      if (bus.btn_level[0] === 1'b1 && first_lvl < 0) first_lvl = j;
      if ((bus.btn_level[3:1] | bus.btn_pulse[3:1]) !== 3'b000) stray = 1'b1;
    end
    checks++;
    if (pulses != 1 || first_pulse != 5 || first_lvl != 5 || stray) begin
      errors++;
      $display("FAIL press_latency: pulses=%0d at k+%0d level at k+%0d stray=%0d, required 1 at k+5, k+5, 0", pulses, first_pulse, first_lvl, stray);
    end
  endtask

  task automatic test_bounce();
    int pulses = 0;
    bit leak = 1'b0;
    for (int r = 0; r < 5; r++) begin
      for (int p = 0; p < 4; p++) begin
        bus.btn_raw[2] = (p < 3);
        step();
        checks++;
        if (bus.btn_level !== m_lvl || bus.btn_pulse !== m_pul) begin
          errors++;
          $display("FAIL bounce_model: level=%b pulse=%b, required %b/%b", bus.btn_level, bus.btn_pulse, m_lvl, m_pul);
        end
        if (bus.btn_level[2] !== 1'b0 || bus.btn_pulse[2] !== 1'b0) leak = 1'b1;
      end
    end
    checks++;
    if (leak) begin
      errors++;
      $display("FAIL bounce_filter: bit2 changed during bounce, required level 0 pulse 0");
    end
    bus.btn_raw[2] = 1'b1;
    for (int j = 0; j < 10; j++) begin
      step();
      if (bus.btn_pulse[2] === 1'b1) pulses++;
    end
    checks++;
    if (pulses != 1 || bus.btn_level[2] !== 1'b1) begin
      errors++;
      $display("FAIL bounce_hold: pulses=%0d level2=%b, required 1 and 1", pulses, bus.btn_level[2]);
    end
  endtask

  task automatic test_release();
    logic exp;
    bit bad = 1'b0;
    bus.btn_raw = 4'b0010;
    repeat (10) step();
    checks++;
    if (bus.btn_level[1] !== 1'b1) begin
      errors++;
      $display("FAIL release_pre: level1=%b, required 1", bus.btn_level[1]);
    end
    bus.btn_raw = '0;
    for (int j = 0; j < 8; j++) begin
      step();
      exp = (j < 5);
      if (bus.btn_level[1] !== exp || bus.btn_pulse[1] !== 1'b0 ||
          bus.btn_level !== m_lvl || bus.btn_pulse !== m_pul) begin
        bad = 1'b1;
        $display("FAIL release m+%0d: level=%b pulse=%b, required level1=%b pulse1=0 model %b/%b", j, bus.btn_level, bus.btn_pulse, exp, m_lvl, m_pul);
      end
    end
    checks++;
    if (bad) errors++;
  endtask

  task automatic test_simultaneous();
    logic [N-1:0] exp_pul;
    bus.btn_raw = '0;
    repeat (6) step();
    bus.btn_raw = 4'b1001;
    for (int j = 0; j < 10; j++) begin
      step();
      exp_pul = (j == 5) ? 4'b1001 : 4'b0000;
      checks++;
      if (bus.btn_pulse !== exp_pul || bus.btn_pulse !== m_pul) begin
        errors++;
        $display("FAIL simultaneous k+%0d: pulse=%b, required %b", j, bus.btn_pulse, exp_pul);
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      for (int c = 0; c < int'(N); c++)
        if ($urandom_range(3) == 0) bus.btn_raw[c] = ~bus.btn_raw[c];
      n_rst = ($urandom_range(63) != 0);
      step();
      checks++;
      if (bus.btn_level !== m_lvl || bus.btn_pulse !== m_pul) begin
        errors++;
        $display("FAIL random cycle %0d: level=%b pulse=%b, required %b/%b", i, bus.btn_level, bus.btn_pulse, m_lvl, m_pul);
      end
    end
    n_rst = 1'b1;
  endtask

  task automatic test_long_hold();
    int pulses = 0, first_pulse = -1;
    bus.btn_raw = '0;
    repeat (8) step();
    bus.btn_raw = 4'b1000;
    for (int j = 0; j < 2000; j++) begin
      step();
      if (bus.btn_pulse[3] === 1'b1) begin pulses++; first_pulse = j; end
    end
    checks++;
    if (pulses != 1 || first_pulse != 5 || bus.btn_level[3] !== 1'b1) begin
      errors++;
      $display("FAIL long_hold: pulses=%0d at k+%0d level3=%b, required 1 at k+5, 1", pulses, first_pulse, bus.btn_level[3]);
    end
  endtask

  task automatic test_long_param();
    int pulses = 0, first_pulse = -1, fall = -1;
    bus_long.btn_raw = 4'b0001;
    for (int j = 0; j < 3000; j++) begin
      step();
      if (bus_long.btn_pulse[0] === 1'b1) begin pulses++; first_pulse = j; end
    end
    checks++;
    if (pulses != 1 || first_pulse != int'(D_LONG) + 1 || bus_long.btn_level !== 4'b0001) begin
      errors++;
      $display("FAIL long_param_press: pulses=%0d at k+%0d level=%b, required 1 at k+%0d, 0001", pulses, first_pulse, bus_long.btn_level, D_LONG + 1);
    end
    bus_long.btn_raw = '0;
    pulses = 0;
    for (int j = 0; j < int'(D_LONG) + 10; j++) begin
      step();
      if (bus_long.btn_level[0] === 1'b0 && fall < 0) fall = j;
      if (bus_long.btn_pulse !== '0) pulses++;
    end
    checks++;
    if (fall != int'(D_LONG) + 1 || pulses != 0) begin
      errors++;
      $display("FAIL long_param_release: fall at m+%0d pulses=%0d, required m+%0d and 0", fall, pulses, D_LONG + 1);
    end
  endtask

  initial begin
    n_rst = 1'b0;
    bus.btn_raw = '0;
    bus_long.btn_raw = '0;
    model_reset_state();
    test_reset();
    test_clean_press();
    test_bounce();
    test_release();
    test_simultaneous();
    test_random();
    test_long_hold();
    test_long_param();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
